pipeline_hazard_ctrl: RTL

//  Sequences the 5-stage pipeline around the opcode decoder: generates PC/IF-ID write enables
//  and IF/ID, ID/EX, EX/MEM bubble controls for load-use stalls, taken branch/jump flushes,

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and the hazard-controller state type.
// The opcode decoder imports the same package.
package cpu_pkg;

  localparam logic [3:0] OP_ATYPE = 4'h0;
  localparam logic [3:0] OP_LBU   = 4'hA;
  localparam logic [3:0] OP_LW    = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hazard_state_t;

  // True when the EX-stage load writes a register the ID instruction reads.
  // R0 is treated like any other register.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [3:0] rd,
                                        input logic [3:0] rs1,
                                        input logic [3:0] rs2,
                                        input logic       uses_rs2);
    return mem_read && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_r;

  // Count enabled cycles, clear has priority, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// multi-cycle op sequencing with timeout, and HALT drain.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int MC_TIMEOUT   = 32,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mc_op,
  input  logic              mc_done,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              mc_start,
  output logic              halted,
  output logic              mc_error,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  hazard_state_t state_r, state_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s;
  logic [3:0]    drain_cnt_r, drain_nxt_s;
  logic          mc_error_r, mc_err_set_s;
  logic          load_use_s;
  logic          stall_en_s;

  assign load_use_s = load_use_hit(ex_mem_read, 4'(ex_rd), 4'(id_rs1), 4'(id_rs2), id_uses_rs2);

  // Next-state and pipeline control outputs from current state and hazard inputs.
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    drain_nxt_s  = drain_cnt_r;
    mc_err_set_s = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    mc_start     = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b0;
      mc_start    = 1'b0;
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mc_op) begin
            mc_start    = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_flush = 1'b1;
            state_nxt_s = MC_WAIT;
            timer_nxt_s = '0;
          end else if (load_use_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (id_opcode == OP_HALT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            state_nxt_s = DRAIN;
            drain_nxt_s = 4'd0;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MC_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_flush = 1'b1;
          if (mc_done) begin
            // Result advances out of EX; the held pipeline resumes.
            exmem_flush = 1'b0;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            state_nxt_s = RUN;
          end else if (timer_r == TIMER_LAST) begin
            // Abandon the op: squash it in ID/EX and report the error.
            mc_err_set_s = 1'b1;
            idex_flush   = 1'b1;
            state_nxt_s  = RUN;
          end else begin
            timer_nxt_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        DRAIN: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (drain_cnt_r == DRAIN_LAST) begin
            state_nxt_s = HALTED;
          end else begin
            drain_nxt_s = drain_cnt_r + 4'd1;
          end
        end
        HALTED: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // State, timers and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      timer_r     <= '0;
      drain_cnt_r <= 4'd0;
      mc_error_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      drain_cnt_r <= drain_nxt_s;
      mc_error_r  <= mc_error_r | mc_err_set_s;
    end
  end

  assign halted   = (state_r == HALTED);
  assign mc_error = mc_error_r;

  // Stalled cycles are counted everywhere except once halted.
  assign stall_en_s = !pc_write && (state_r != HALTED) && !rst;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (stall_en_s),
    .q   (stall_cycles)
  );

endmodule
